// File: rtl/sram_arb_pkg.sv
// Shared types and default sizing for the SRAM port arbiter.
package sram_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int DEF_NREQ      = 4;
    localparam int DEF_DEPTH     = 8;
    localparam int DEF_WIDTH     = 128;
    localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority picker: first set bit of req at or after start, wrapping modulo N.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [N-1:0] grant
);

    always_comb begin
        int   j;
        logic found;
        grant = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(start) + i;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_port_arb.sv
// Single-port SRAM arbiter: round-robin grant with optional locked bursts.
// Define SRAM_ARB_HIPRI_EN to give requester 0 absolute priority while idle.
//   state  | meaning
//   IDLE   | round-robin (or hi-pri) arbitration among all requesters
//   LOCKED | only owner is eligible until lock drops, burst ends or owner idles
module sram_port_arb
    import sram_arb_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BURST = DEF_MAX_BURST,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int BW = $clog2(MAX_BURST + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_val,
    input  logic [NREQ-1:0]           req_we,
    input  logic [NREQ-1:0]           req_lock,
    input  logic [NREQ-1:0][AW-1:0]   req_addr,
    input  logic [NREQ-1:0][WIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]           req_rdy,
    output logic [NREQ-1:0]           rsp_val,
    output logic [WIDTH-1:0]          rsp_data,
    output logic                      sram_ce_b,
    output logic                      sram_we_b,
    output logic [AW-1:0]             sram_addr,
    output logic [WIDTH-1:0]          sram_data_in,
    input  logic [WIDTH-1:0]          sram_data_out
);

    arb_state_e     state;
    logic [PW-1:0]  rr_ptr;
    logic [PW-1:0]  owner;
    logic [BW-1:0]  beat_cnt;
    logic [NREQ-1:0] rr_grant;
    logic [NREQ-1:0] grant;
    logic [PW-1:0]  gidx;
    logic [PW-1:0]  nxt_ptr;
    logic           xfer;

    rr_pick #(.N(NREQ), .W(PW)) u_rr_pick (
        .req   (req_val),
        .start (rr_ptr),
        .grant (rr_grant)
    );

    always_comb begin
        grant = '0;
        if (!rst) begin
            if (state == LOCKED) begin
                grant[owner] = req_val[owner];
            end else begin
`ifdef SRAM_ARB_HIPRI_EN
                if (req_val[0]) grant[0] = 1'b1;
                else            grant    = rr_grant;
`else
                grant = rr_grant;
`endif
            end
        end
    end

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) gidx = PW'(i);
        end
    end

    assign xfer         = |grant;
    assign nxt_ptr      = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
    assign req_rdy      = grant;
    assign sram_ce_b    = ~xfer;
    assign sram_we_b    = ~(xfer & req_we[gidx]);
    assign sram_addr    = xfer ? req_addr[gidx]  : '0;
    assign sram_data_in = xfer ? req_wdata[gidx] : '0;
    // SRAM read data lands one clock after the access, aligned with rsp_val.
    assign rsp_data     = (|rsp_val) ? sram_data_out : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
            rsp_val  <= '0;
        end else begin
            rsp_val <= grant & ~req_we;
            if (xfer) rr_ptr <= nxt_ptr;
            case (state)
                IDLE: begin
                    if (xfer && req_lock[gidx] && (MAX_BURST > 1)) begin
                        state    <= LOCKED;
                        owner    <= gidx;
                        beat_cnt <= BW'(1);
                    end
                end
                LOCKED: begin
                    if (!xfer || !req_lock[owner] || (beat_cnt == BW'(MAX_BURST - 1))) begin
                        state    <= IDLE;
                        beat_cnt <= '0;
                    end else begin
                        beat_cnt <= beat_cnt + BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arb.sv
// Directed bench for sram_port_arb with a behavioural 1-cycle-latency SRAM.
module tb_sram_port_arb;
    import sram_arb_pkg::*;

`ifdef SRAM_ARB_HIPRI_EN
    localparam bit HIPRI = 1'b1;
`else
    localparam bit HIPRI = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [3:0]        req_val;
    logic [3:0]        req_we;
    logic [3:0]        req_lock;
    logic [3:0][2:0]   req_addr;
    logic [3:0][127:0] req_wdata;
    logic [3:0]        req_rdy;
    logic [3:0]        rsp_val;
    logic [127:0]      rsp_data;
    logic              sram_ce_b;
    logic              sram_we_b;
    logic [2:0]        sram_addr;
    logic [127:0]      sram_data_in;
    logic [127:0]      sram_data_out;

    logic [127:0] mem [8];
    int n_checks = 0;
    int n_fail   = 0;

    sram_port_arb dut (
        .clk           (clk),
        .rst           (rst),
        .req_val       (req_val),
        .req_we        (req_we),
        .req_lock      (req_lock),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_rdy       (req_rdy),
        .rsp_val       (rsp_val),
        .rsp_data      (rsp_data),
        .sram_ce_b     (sram_ce_b),
        .sram_we_b     (sram_we_b),
        .sram_addr     (sram_addr),
        .sram_data_in  (sram_data_in),
        .sram_data_out (sram_data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (!sram_ce_b) begin
            if (!sram_we_b) mem[sram_addr] <= sram_data_in;
            else            sram_data_out  <= mem[sram_addr];
        end
    end

    task automatic drive(input logic [3:0] val, input logic [3:0] we, input logic [3:0] lock);
        @(negedge clk);
        req_val  = val;
        req_we   = we;
        req_lock = lock;
        #1;
    endtask

    task automatic chk_rdy(input string name, input logic [3:0] exp);
        n_checks++;
        if (req_rdy !== exp) begin
            n_fail++;
            $display("FAIL %s req_rdy got %b exp %b", name, req_rdy, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_val = 4'hF; req_we = 4'h0; req_lock = 4'hF;
        #1;
        n_checks++;
        if (req_rdy !== 4'b0000 || sram_ce_b !== 1'b1 || sram_we_b !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_outputs rdy=%b ce_b=%b we_b=%b exp 0000/1/1", req_rdy, sram_ce_b, sram_we_b);
        end
        n_checks++;
        if (rsp_val !== 4'b0000 || rsp_data !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_rsp rsp_val=%b rsp_data=%h exp 0/0", rsp_val, rsp_data);
        end
        @(negedge clk);
        req_val = 4'h0; req_lock = 4'h0;
        rst = 1'b0;
    endtask

    task automatic test_rr_reads();
        int prev;
        int expg;
        prev = 0;
        for (int g = 0; g < 4; g++) req_addr[g] = 3'(g);
        for (int k = 0; k < 5; k++) begin
            drive(4'hF, 4'h0, 4'h0);
            expg = HIPRI ? 0 : (k % 4);
            chk_rdy("rr_grant", 4'(1 << expg));
            n_checks++;
            if (sram_ce_b !== 1'b0 || sram_we_b !== 1'b1 || sram_addr !== 3'(expg)) begin
                n_fail++;
                $display("FAIL rr_sram ce_b=%b we_b=%b addr=%0d exp 0/1/%0d", sram_ce_b, sram_we_b, sram_addr, expg);
            end
            if (k > 0) begin
                n_checks++;
                if (rsp_val !== 4'(1 << prev) || rsp_data !== 128'h1000 + 128'(prev)) begin
                    n_fail++;
                    $display("FAIL rr_rsp rsp_val=%b data=%h exp %0d/%h", rsp_val, rsp_data, prev, 128'h1000 + 128'(prev));
                end
            end
            prev = expg;
        end
        drive(4'h0, 4'h0, 4'h0);
        n_checks++;
        if (rsp_val !== 4'b0001 || rsp_data !== 128'h1000 || sram_ce_b !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_last_rsp rsp_val=%b data=%h ce_b=%b exp 0001/1000/1", rsp_val, rsp_data, sram_ce_b);
        end
        drive(4'h0, 4'h0, 4'h0);
        n_checks++;
        if (rsp_val !== 4'b0000 || rsp_data !== 128'h0) begin
            n_fail++;
            $display("FAIL rsp_zero rsp_val=%b data=%h exp 0/0", rsp_val, rsp_data);
        end
    endtask

    task automatic test_write_read();
        req_addr[2] = 3'd5; req_wdata[2] = 128'hA5;
        req_addr[1] = 3'd5;
        drive(4'b0100, 4'b0100, 4'h0);
        chk_rdy("wr_grant", 4'b0100);
        n_checks++;
        if (sram_we_b !== 1'b0 || sram_addr !== 3'd5 || sram_data_in !== 128'hA5) begin
            n_fail++;
            $display("FAIL wr_sram we_b=%b addr=%0d din=%h exp 0/5/a5", sram_we_b, sram_addr, sram_data_in);
        end
        drive(4'b0010, 4'b0000, 4'h0);
        chk_rdy("rd_grant", 4'b0010);
        n_checks++;
        if (rsp_val !== 4'b0000) begin
            n_fail++;
            $display("FAIL wr_no_rsp rsp_val=%b exp 0000", rsp_val);
        end
        drive(4'h0, 4'h0, 4'h0);
        n_checks++;
        if (rsp_val !== 4'b0010 || rsp_data !== 128'hA5) begin
            n_fail++;
            $display("FAIL rd_rsp rsp_val=%b data=%h exp 0010/a5", rsp_val, rsp_data);
        end
    endtask

    task automatic test_lock_burst();
        logic [3:0] exp_g [6];
        exp_g = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0010};
        req_addr[0] = 3'd0; req_addr[1] = 3'd1; req_addr[3] = 3'd3;
        drive(4'b0001, 4'h0, 4'h0);
        chk_rdy("lock_prelude", 4'b0001);
        for (int k = 0; k < 6; k++) begin
            drive((k < 5) ? 4'b1010 : 4'b0010, 4'h0, 4'b0010);
            chk_rdy("lock_burst", exp_g[k]);
        end
        drive(4'h0, 4'h0, 4'h0);
        chk_rdy("lock_release", 4'b0000);
    endtask

    task automatic test_lock_drop();
        req_addr[2] = 3'd2;
        drive(4'b1100, 4'h0, 4'b0100);
        chk_rdy("drop_first", 4'b0100);
        drive(4'b1100, 4'h0, 4'b0100);
        chk_rdy("drop_owner", 4'b0100);
        drive(4'b1000, 4'h0, 4'b0100);
        chk_rdy("drop_nogrant", 4'b0000);
        n_checks++;
        if (sram_ce_b !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_ce_b got %b exp 1", sram_ce_b);
        end
        drive(4'b1100, 4'h0, 4'h0);
        chk_rdy("drop_rr", 4'b1000);
        drive(4'h0, 4'h0, 4'h0);
    endtask

    task automatic test_reset_pending();
        drive(4'b0010, 4'h0, 4'b0010);
        chk_rdy("rstp_read", 4'b0010);
        @(negedge clk);
        rst = 1'b1;
        req_val = 4'h0; req_lock = 4'h0;
        #1;
        n_checks++;
        if (rsp_val !== 4'b0000 || req_rdy !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstp_during rsp_val=%b rdy=%b exp 0/0", rsp_val, req_rdy);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (rsp_val !== 4'b0000 || dut.state !== IDLE || dut.rr_ptr !== 2'd0 || dut.beat_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL rstp_after rsp_val=%b state=%0d rr_ptr=%0d beat=%0d exp 0/0/0/0",
                     rsp_val, dut.state, dut.rr_ptr, dut.beat_cnt);
        end
        drive(4'hF, 4'h0, 4'h0);
        chk_rdy("rstp_grant0", 4'b0001);
        drive(4'h0, 4'h0, 4'h0);
    endtask

    task automatic test_hipri();
        logic [3:0] exp_g [4];
        if (HIPRI) exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
        else       exp_g = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};
        drive(4'b0010, 4'h0, 4'h0);
        chk_rdy("hipri_setup", 4'b0010);
        for (int k = 0; k < 4; k++) begin
            drive(4'b0101, 4'h0, 4'h0);
            chk_rdy("hipri_seq", exp_g[k]);
        end
        drive(4'h0, 4'h0, 4'h0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 128'h1000 + 128'(i);
        sram_data_out = '0;
        req_addr  = '0;
        req_wdata = '0;
        test_reset();
        test_rr_reads();
        test_write_read();
        test_lock_burst();
        test_lock_drop();
        test_reset_pending();
        test_hipri();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/sram_port_arb.md
SRAM_PORT_ARB -- requirements
Module: sram_port_arb

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NREQ, 4, number of requesters
- DEPTH, 8, SRAM entries
- WIDTH, 128, data bits per entry
- MAX_BURST, 4, maximum beats per locked grant
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, the single clock
- rst, in, 1, reset, asynchronous, active-high
- req_val, in, NREQ, per-requester access valid
- req_we, in, NREQ, 1 = write, 0 = read
- req_lock, in, NREQ, request to hold the grant for the next beat
- req_addr, in, NREQ x clog2(DEPTH), access address
- req_wdata, in, NREQ x WIDTH, write data
- req_rdy, out, NREQ, grant; one-hot or zero
- rsp_val, out, NREQ, read data valid, per requester
- rsp_data, out, WIDTH, read data, shared by all requesters
- sram_ce_b, out, 1, SRAM chip enable, active-low
- sram_we_b, out, 1, SRAM write enable, active-low
- sram_addr, out, clog2(DEPTH), SRAM address
- sram_data_in, out, WIDTH, SRAM write data
- sram_data_out, in, WIDTH, SRAM read data; valid 1 clk after a read access
REQ-003 One clock; reset is asynchronous and active-high, ports named clk and rst.

Function
REQ-004 Transfer on requester g SHALL occur in a cycle where req_val[g] & req_rdy[g]; at most one transfer per cycle.
REQ-005 req_rdy SHALL be combinational from req_val, state, rr_ptr and owner; req_rdy[g] never asserts without req_val[g].
REQ-006 On transfer: sram_ce_b=0, sram_we_b=~req_we[g], sram_addr=req_addr[g], sram_data_in=req_wdata[g]; otherwise sram_ce_b=1, sram_we_b=1.
REQ-007 Read transfer on g in cycle N SHALL assert rsp_val[g] in cycle N+1 only, with rsp_data=sram_data_out; write transfers produce no response.
REQ-008 rsp_data SHALL be 0 whenever rsp_val is all-zero.
REQ-009 State IDLE: grant SHALL go to the first requester with req_val set, searching from index rr_ptr upward modulo NREQ.
REQ-010 On every transfer, rr_ptr SHALL become (g+1) mod NREQ.
REQ-011 IDLE->LOCKED on a transfer with req_lock[g]=1 when MAX_BURST>1; owner=g, beat_cnt=1.
REQ-012 LOCKED: only the owner is eligible.
- Each owner transfer increments beat_cnt.
- Return to IDLE after a transfer with req_lock=0, or when beat_cnt reaches MAX_BURST.
REQ-013 LOCKED with req_val[owner]=0: no grant that cycle; return to IDLE next cycle.
REQ-014 beat_cnt SHALL be clog2(MAX_BURST+1) bits wide and never exceed MAX_BURST.
REQ-015 Simultaneous read response and new transfer SHALL both proceed (back-to-back reads at 1 access/clk).

Reset
REQ-016 rst SHALL force: state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, rsp_val=0, req_rdy=0, sram_ce_b=1, sram_we_b=1.
REQ-017 A read pending when rst asserts SHALL produce no rsp_val after reset; a lock held at reset is released.

Configuration
REQ-018 With SRAM_ARB_HIPRI_EN defined, requester 0 SHALL win in IDLE whenever req_val[0]=1.
- It does not preempt LOCKED.
- rr_ptr still updates per REQ-010.
REQ-019 Without SRAM_ARB_HIPRI_EN, arbitration SHALL be pure round-robin per REQ-009.

Structure
REQ-020 Package sram_arb_pkg SHALL hold the state enum (IDLE, LOCKED) and the default NREQ, DEPTH, WIDTH and MAX_BURST constants.
REQ-021 Sub-module rr_pick (combinational: req vector + start index -> one-hot grant) SHALL be instantiated once.

Verification
REQ-022 Reset, then all four req_val=1 with read access: grants go 0,1,2,3,0; rsp_val follows each grant by 1 clk.
REQ-023 Req 2 writes addr 5 = 0xA5, then req 1 reads addr 5: rsp_val[1]=1 one clk after the read, with rsp_data=0xA5.
REQ-024 Req 1 holds req_lock=1 for 6 beats while req 3 also requests: req 1 gets 4 consecutive grants, then req 3 is granted.
REQ-025 In LOCKED, owner drops req_val for 1 clk: no grant that clk; the next clk grants by round-robin.
REQ-026 rst asserted the cycle after a read transfer: rsp_val stays 0, state=IDLE, rr_ptr=0.
REQ-027 With SRAM_ARB_HIPRI_EN, req 0 and req 2 both request continuously with rr_ptr=2: req 0 wins every cycle; without the macro, grants alternate 2,0,2,0.
